// File: rtl/iommu_xlate_ctrl.sv
// Translation controller between a DMA master, the iommu_ioatc cache and a page-table walker.
// One translation in flight; cache flush after reset and on invalidate-all requests.
//
//   state      | meaning
//   INIT_FLUSH | post-reset cache flush, requests blocked
//   IDLE       | waiting for a request or an invalidate
//   LOOKUP     | cache lookup issued, waiting for atc_done
//   WALK       | miss, waiting for the page-table walker
//   UPDATE     | writing the walker result into the cache
//   RESP       | one-cycle response pulse
//   FLUSH      | invalidate-all flush, ends with inv_done
module iommu_xlate_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] req_iova,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_pa,
    output logic        resp_fault,
    output logic [63:0] atc_iova,
    output logic        atc_iova_ready,
    input  logic [63:0] atc_pa,
    input  logic        atc_done,
    input  logic        atc_hit,
    output logic [63:0] atc_new_iova,
    output logic [63:0] atc_new_pa,
    output logic        atc_update_ready,
    input  logic        atc_update_done,
    output logic        atc_flush,
    input  logic        atc_flush_done,
    output logic        ptw_req,
    output logic [63:0] ptw_iova,
    input  logic        ptw_done,
    input  logic [63:0] ptw_pa,
    input  logic        ptw_fault,
    input  logic        inv_req,
    output logic        inv_done,
    output logic        err_timeout,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam logic [2:0] S_INIT_FLUSH = 3'd0;
    localparam logic [2:0] S_IDLE       = 3'd1;
    localparam logic [2:0] S_LOOKUP     = 3'd2;
    localparam logic [2:0] S_WALK       = 3'd3;
    localparam logic [2:0] S_UPDATE     = 3'd4;
    localparam logic [2:0] S_RESP       = 3'd5;
    localparam logic [2:0] S_FLUSH      = 3'd6;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES);

    logic [2:0]    state;
    logic [63:0]   iova_q;
    logic [63:0]   fill_pa_q;
    logic [CW-1:0] wait_cnt;
    logic          init_start;
    logic          timed_out;
    logic          accept;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign timed_out    = (wait_cnt == '0);
    // inv_done gating keeps a still-high inv_req from re-triggering a flush in the done cycle
    assign req_ready    = (state == S_IDLE) && !inv_req && !inv_done;
    assign accept       = req_valid && req_ready;
    assign atc_iova     = (state == S_LOOKUP || state == S_UPDATE) ? iova_q : '0;
    assign ptw_req      = (state == S_WALK);
    assign ptw_iova     = ptw_req ? iova_q : '0;
    assign atc_new_iova = (state == S_UPDATE) ? iova_q : '0;
    assign atc_new_pa   = (state == S_UPDATE) ? fill_pa_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_INIT_FLUSH;
            init_start       <= 1'b1;
            iova_q           <= '0;
            fill_pa_q        <= '0;
            wait_cnt         <= TO_LOAD;
            resp_valid       <= 1'b0;
            resp_pa          <= '0;
            resp_fault       <= 1'b0;
            atc_iova_ready   <= 1'b0;
            atc_update_ready <= 1'b0;
            atc_flush        <= 1'b0;
            inv_done         <= 1'b0;
            err_timeout      <= 1'b0;
            hit_cnt          <= '0;
            miss_cnt         <= '0;
        end else begin
            resp_valid       <= 1'b0;
            atc_iova_ready   <= 1'b0;
            atc_update_ready <= 1'b0;
            atc_flush        <= 1'b0;
            inv_done         <= 1'b0;
            if (!timed_out) wait_cnt <= wait_cnt - 1'b1;

            case (state)
                S_INIT_FLUSH: begin
                    if (init_start) begin
                        atc_flush  <= 1'b1;
                        init_start <= 1'b0;
                        wait_cnt   <= TO_LOAD;
                    end else if (atc_flush_done) begin
                        state <= S_IDLE;
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (inv_req && !inv_done) begin
                        state     <= S_FLUSH;
                        atc_flush <= 1'b1;
                        wait_cnt  <= TO_LOAD;
                    end else if (accept) begin
                        iova_q <= req_iova;
                        if (req_iova[63:39] != '0) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_pa    <= '0;
                            resp_fault <= 1'b1;
                        end else begin
                            state          <= S_LOOKUP;
                            atc_iova_ready <= 1'b1;
                            wait_cnt       <= TO_LOAD;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (atc_done) begin
                        if (atc_hit) begin
                            hit_cnt    <= sat_inc(hit_cnt);
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_pa    <= atc_pa;
                            resp_fault <= 1'b0;
                        end else begin
                            miss_cnt <= sat_inc(miss_cnt);
                            state    <= S_WALK;
                        end
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        state       <= S_RESP;
                        resp_valid  <= 1'b1;
                        resp_pa     <= '0;
                        resp_fault  <= 1'b1;
                    end
                end
                S_WALK: begin
                    if (ptw_done) begin
                        if (ptw_fault || ptw_pa[63:56] != '0) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_pa    <= '0;
                            resp_fault <= 1'b1;
                        end else begin
                            fill_pa_q        <= ptw_pa;
                            state            <= S_UPDATE;
                            atc_update_ready <= 1'b1;
                            wait_cnt         <= TO_LOAD;
                        end
                    end
                end
                S_UPDATE: begin
                    if (atc_update_done) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_pa    <= {fill_pa_q[63:12], iova_q[11:0]};
                        resp_fault <= 1'b0;
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        state       <= S_RESP;
                        resp_valid  <= 1'b1;
                        resp_pa     <= '0;
                        resp_fault  <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                S_FLUSH: begin
                    if (atc_flush_done) begin
                        inv_done <= 1'b1;
                        state    <= S_IDLE;
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        inv_done    <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_INIT_FLUSH;
                end
            endcase
        end
    end

endmodule

// File: doc/iommu_xlate_ctrl.md
# iommu_xlate_ctrl

Translation controller that sits between a DMA master and the `iommu_ioatc` translation cache. It accepts one IOVA at a time from the device side and issues the lookup to the cache. On a miss it asks an external page-table walker for the translation, writes that translation back into the cache and returns the physical address. It also drives cache flushes: one automatically after reset, and others on request from the invalidation path.

## Interface
- `TIMEOUT_CYCLES`, default 1023: maximum number of cycles to wait for any single cache response (`atc_done`, `atc_update_done`, `atc_flush_done`). Must be ≥ 200.
- `clk` in 1: clock; everything is sampled on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1, `req_iova` in 64, `req_ready` out 1: translation request; accepted on any cycle where `req_valid & req_ready`.
- `resp_valid` out 1, `resp_pa` out 64, `resp_fault` out 1: result; `resp_valid` is a one-cycle pulse with no backpressure.
- `atc_iova` out 64, `atc_iova_ready` out 1: cache lookup address and lookup strobe.
- `atc_pa` in 64, `atc_done` in 1, `atc_hit` in 1: cache lookup result.
- `atc_new_iova` out 64, `atc_new_pa` out 64, `atc_update_ready` out 1, `atc_update_done` in 1: cache fill.
- `atc_flush` out 1, `atc_flush_done` in 1: cache flush.
- `ptw_req` out 1, `ptw_iova` out 64: walker request; `ptw_req` is a level held until `ptw_done`.
- `ptw_done` in 1, `ptw_pa` in 64, `ptw_fault` in 1: walker result; `ptw_done` is a one-cycle pulse.
- `inv_req` in 1, `inv_done` out 1: invalidate-all. `inv_req` is a level held until the `inv_done` pulse.
- `err_timeout` out 1: sticky cache-timeout flag, cleared only by `rst`.
- `hit_cnt` out 32, `miss_cnt` out 32: saturating statistics counters.

## Operation
- States: INIT_FLUSH, IDLE, LOOKUP, WALK, UPDATE, RESP, FLUSH.
- Reset:
  - All outputs go to 0; the state goes to INIT_FLUSH.
  - The cache has no reset, so after every reset it is flushed before any request is accepted.
- INIT_FLUSH and FLUSH:
  - Pulse `atc_flush` for one cycle, then wait for `atc_flush_done`.
  - FLUSH then pulses `inv_done` for one cycle; INIT_FLUSH does not.
  - Both go to IDLE.
- IDLE:
  - `req_ready` = 1 only in IDLE and only when `inv_req` = 0; invalidation has priority over a new request.
  - On acceptance, latch `req_iova`.
  - If `req_iova[63:39]` ≠ 0 (the address is outside the cache tag range), go directly to RESP with a fault.
  - Otherwise go to LOOKUP.
- LOOKUP:
  - On the first cycle, pulse `atc_iova_ready` for exactly one cycle.
  - Hold `atc_iova` = latched IOVA until `atc_done`, because the cache forms the page offset from the live address.
  - `atc_done & atc_hit`: capture `atc_pa`, increment `hit_cnt`, go to RESP.
  - `atc_done & !atc_hit`: increment `miss_cnt`, go to WALK.
- WALK:
  - Hold `ptw_req` = 1 and `ptw_iova` = IOVA until `ptw_done`.
  - `ptw_fault`, or `ptw_pa[63:56]` ≠ 0: fault response, no cache fill.
  - Otherwise go to UPDATE.
- UPDATE:
  - Pulse `atc_update_ready` for one cycle with `atc_new_iova` = IOVA and `atc_new_pa` = `ptw_pa`.
  - Drive `atc_iova` = IOVA as well, because the cache takes the set index from `atc_iova[18:12]`.
  - Hold all three until `atc_update_done`, then go to RESP with PA = {`ptw_pa[63:12]`, IOVA[11:0]}.
- RESP:
  - Pulse `resp_valid` for one cycle.
  - `resp_pa` holds the translated PA, or 0 on a fault; `resp_fault` is valid with it.
  - `resp_pa` and `resp_fault` hold their values until the next response.
  - Go to IDLE.
- Timeout:
  - A wait counter restarts on entry to LOOKUP, UPDATE, FLUSH and INIT_FLUSH.
  - When it reaches `TIMEOUT_CYCLES`, set `err_timeout`.
  - LOOKUP or UPDATE: go to RESP with a fault.
  - FLUSH: still pulse `inv_done`. INIT_FLUSH: go to IDLE.
  - WALK has no timeout.
- Invalidation:
  - An `inv_req` raised mid-translation is serviced only after that translation's RESP.
  - Requests never overlap; at most one translation is in flight.
- Counters saturate at 32'hFFFF_FFFF; only `rst` clears them.

## Timing
- Hit path, with cycle 0 = acceptance:
  - `atc_iova_ready` high in cycle 1.
  - `atc_done` high in cycle 3.
  - `resp_valid` high in cycle 4.
- Miss path: `ptw_req` rises in the cycle after `atc_done` is sampled. `atc_update_ready` is high in the cycle after `ptw_done`. `resp_valid` is high in the cycle after `atc_update_done`.
- Out-of-range fault: `resp_valid` high in cycle 1.
- `req_ready` is low from acceptance through the RESP cycle; it is high again the cycle after `resp_valid`.
- Flush: `atc_flush` high for one cycle. After reset release, `req_ready` stays 0 until the cycle after `atc_flush_done`, which is about 130 cycles.
- `rst` asserted mid-operation clears every output immediately, the in-flight request is dropped, and INIT_FLUSH re-runs. An in-flight walker result arriving after reset is ignored.

## Test plan
- Post-reset flush:
  - Release `rst`: `atc_flush` pulses once and `req_ready` = 0 until `atc_flush_done`.
  - An `iommu_ioatc` model gets flushed, and `inv_done` stays 0 throughout.
- Miss then hit:
  - First request, `req_iova` = 0x0000_0040_1234_5ABC: `ptw_req` asserted. Answer `ptw_pa` = 0x0080_0000_0000_0000: `atc_update_ready` pulses with `atc_iova[18:12]` = 0x45.
  - Response `resp_pa` = 0x0080_0000_0000_0ABC, fault = 0, `miss_cnt` = 1.
  - The same request again: a hit with the same PA in 4 cycles, `hit_cnt` = 1, no `ptw_req`.
- Faults:
  - IOVA 0x0000_8000_0000_0000: fault in cycle 1 with no `atc_iova_ready`.
  - Walker returns `ptw_fault` = 1: `resp_fault` = 1, `resp_pa` = 0, no `atc_update_ready`.
- Invalidate during walk: raise `inv_req` while in WALK.
  - The translation completes first, then `atc_flush` pulses, then `inv_done` pulses once.
  - A re-request of the same IOVA then misses.
- Timeout: with `TIMEOUT_CYCLES` = 200, the cache never answers a lookup. Required: `resp_fault` = 1 at cycle ~202 after acceptance and `err_timeout` = 1, staying 1 until `rst`.
- Reset in UPDATE: assert `rst` while `atc_update_ready` is pending. All outputs are 0 immediately, INIT_FLUSH runs, and the counters read 0.
